quad_encoder_if: RTL and testbench

//  Parametrised quadrature encoder interface: synchroniser + glitch filter on A/B/Z, x4 decode,

---
 rtl/quad_encoder_if.sv | 175 +++++++++++++++++
 tb/tb_quad_encoder_if.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_if.sv
// Quadrature encoder front end: per-channel synchroniser and glitch filter on
// A/B/Z, x4 decode into a wrapping shaft position and signed running count,
// index pulse handling, illegal-transition counting and windowed velocity.
module quad_encoder_if #(
  parameter int PPR       = 334,
  parameter int CNT_W     = 32,
  parameter int FILT_LEN  = 4,
  parameter int VEL_WIN   = 100000,
  parameter int VEL_W     = 16,
  parameter int ERR_W     = 8,
  parameter int INDEX_RST = 1,
  localparam int POS_W    = $clog2(4*PPR)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    qa,
  input  logic                    qb,
  input  logic                    qz,
  output logic                    dir,
  output logic                    step,
  output logic [POS_W-1:0]        pos,
  output logic signed [CNT_W-1:0] cnt,
  output logic signed [VEL_W-1:0] vel,
  output logic                    vel_valid,
  output logic                    idx,
  output logic                    err,
  output logic [ERR_W-1:0]        err_cnt
);

  localparam int FCNT_W = $clog2(FILT_LEN + 1);
  localparam int WIN_W  = $clog2(VEL_WIN);
  localparam logic [POS_W-1:0]        POS_MAX   = POS_W'(4*PPR - 1);
  localparam logic signed [VEL_W-1:0] DELTA_MAX = {1'b0, {(VEL_W-1){1'b1}}};
  localparam logic signed [VEL_W-1:0] DELTA_MIN = {1'b1, {(VEL_W-1){1'b0}}};

  // Channel order in the vectors below is {Z, B, A}.
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] filt;

  // Two-flop synchroniser for the asynchronous encoder pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {qz, qb, qa};
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_filt
    logic              filt_q;
    logic [FCNT_W-1:0] fcnt;

    // Accept a new level only after it has differed for FILT_LEN straight cycles.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        filt_q <= 1'b0;
        fcnt   <= '0;
      end else if (sync2[i] == filt_q) begin
        fcnt <= '0;
      end else if (fcnt == FCNT_W'(FILT_LEN - 1)) begin
        filt_q <= sync2[i];
        fcnt   <= '0;
      end else begin
        fcnt <= fcnt + FCNT_W'(1);
      end
    end

    assign filt[i] = filt_q;
  end

  logic [1:0] prev_ab;
  logic       z_prev;
  logic [1:0] cur_ph;
  logic [1:0] prev_ph;
  logic [1:0] ph_diff;
  logic       fwd;
  logic       rev;
  logic       bad;
  logic       z_rise;
  logic signed [VEL_W-1:0] delta;
  logic signed [VEL_W-1:0] delta_next;
  logic [WIN_W-1:0]        win;

  // Map Gray-coded {B,A} to a phase 0..3 so direction falls out of a modulo-4 difference.
  always_comb begin
    cur_ph  = {filt[1], filt[1] ^ filt[0]};
    prev_ph = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
    ph_diff = cur_ph - prev_ph;
    fwd     = (ph_diff == 2'd1);
    rev     = (ph_diff == 2'd3);
    bad     = (ph_diff == 2'd2);
    z_rise  = filt[2] & ~z_prev;
  end

  // Saturating per-window step accumulator input.
  always_comb begin
    delta_next = delta;
    if (fwd && delta != DELTA_MAX) begin
      delta_next = delta + VEL_W'(1);
    end else if (rev && delta != DELTA_MIN) begin
      delta_next = delta - VEL_W'(1);
    end
  end

  // Decode: step/dir/pos/cnt, index and illegal-transition bookkeeping; clr wins over updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_ab <= 2'b00;
      z_prev  <= 1'b0;
      step    <= 1'b0;
      dir     <= 1'b0;
      idx     <= 1'b0;
      err     <= 1'b0;
      pos     <= '0;
      cnt     <= '0;
      err_cnt <= '0;
    end else begin
      prev_ab <= filt[1:0];
      z_prev  <= filt[2];
      step    <= fwd | rev;
      idx     <= z_rise;
      err     <= bad;
      if (fwd) begin
        dir <= 1'b1;
      end else if (rev) begin
        dir <= 1'b0;
      end
      if (clr) begin
        pos     <= '0;
        cnt     <= '0;
        err_cnt <= '0;
      end else begin
        if (fwd) begin
          cnt <= cnt + CNT_W'(1);
        end else if (rev) begin
          cnt <= cnt - CNT_W'(1);
        end
        if (INDEX_RST != 0 && z_rise) begin
          pos <= '0;
        end else if (fwd) begin
          pos <= (pos == POS_MAX) ? '0 : pos + POS_W'(1);
        end else if (rev) begin
          pos <= (pos == '0) ? POS_MAX : pos - POS_W'(1);
        end
        if (bad && err_cnt != '1) begin
          err_cnt <= err_cnt + ERR_W'(1);
        end
      end
    end
  end

  // Velocity window: publish the step total (including this cycle's step) at window end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win       <= '0;
      delta     <= '0;
      vel       <= '0;
      vel_valid <= 1'b0;
    end else if (win == WIN_W'(VEL_WIN - 1)) begin
      vel       <= delta_next;
      vel_valid <= 1'b1;
      delta     <= '0;
      win       <= '0;
    end else begin
      vel_valid <= 1'b0;
      delta     <= delta_next;
      win       <= win + WIN_W'(1);
    end
  end

endmodule

// File: tb/tb_quad_encoder_if.sv
// Bench for quad_encoder_if: table-driven step vectors plus hand-written
// sequences for filter, wrap, index, error saturation, velocity and reset.
module tb_quad_encoder_if;

  localparam int PPR       = 4;
  localparam int CNT_W     = 32;
  localparam int FILT_LEN  = 4;
  localparam int VEL_WIN   = 100;
  localparam int VEL_W     = 16;
  localparam int ERR_W     = 8;
  localparam int INDEX_RST = 1;
  localparam int POS_W     = $clog2(4*PPR);
  localparam int NPOS      = 4*PPR;
  localparam int ERR_MAX   = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic qa  = 1'b0;
  logic qb  = 1'b0;
  logic qz  = 1'b0;
  logic                    dir;
  logic                    step;
  logic [POS_W-1:0]        pos;
  logic signed [CNT_W-1:0] cnt;
  logic signed [VEL_W-1:0] vel;
  logic                    vel_valid;
  logic                    idx;
  logic                    err;
  logic [ERR_W-1:0]        err_cnt;

  always #5 clk = ~clk;

  quad_encoder_if #(
    .PPR(PPR), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .VEL_WIN(VEL_WIN),
    .VEL_W(VEL_W), .ERR_W(ERR_W), .INDEX_RST(INDEX_RST)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .qa(qa), .qb(qb), .qz(qz),
    .dir(dir), .step(step), .pos(pos), .cnt(cnt), .vel(vel),
    .vel_valid(vel_valid), .idx(idx), .err(err), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [1:0] ab;
    logic       e_err;
    int         e_pos;
    int         e_cnt;
    logic       e_dir;
    int         e_err_cnt;
  } vec_t;

  typedef struct {
    logic e_step;
    logic e_idx;
    logic e_err;
    int   e_pos;
    int   e_cnt;
    logic e_dir;
    int   e_err_cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[9];
  logic [1:0] gray[4];

  int checks = 0;
  int errors = 0;
  int cyc;
  int n_steps = 0;
  int last_step_cyc = 0;
  int vv_seen = 0;
  int vv_cyc = 0;
  int vv_val = 0;

  int         m_pos = 0;
  int         m_cnt = 0;
  int         m_err_cnt = 0;
  logic       m_dir = 1'b0;
  logic [1:0] m_ab = 2'b00;

  task automatic checkOutput(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic int phase_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // Reference model: updates expected state and queues the event the DUT must emit.
  task automatic model_apply(input logic [1:0] ab, input logic z_rise);
    int d;
    exp_t e;
    d = (phase_of(ab) - phase_of(m_ab) + 4) % 4;
    if (d == 1) begin
      m_cnt++;
      m_dir = 1'b1;
      m_pos = (m_pos + 1) % NPOS;
    end else if (d == 3) begin
      m_cnt--;
      m_dir = 1'b0;
      m_pos = (m_pos + NPOS - 1) % NPOS;
    end else if (d == 2 && m_err_cnt < ERR_MAX) begin
      m_err_cnt++;
    end
    if (z_rise) m_pos = 0;
    m_ab = ab;
    e.e_step    = (d == 1 || d == 3);
    e.e_err     = (d == 2);
    e.e_idx     = z_rise;
    e.e_pos     = m_pos;
    e.e_cnt     = m_cnt;
    e.e_dir     = m_dir;
    e.e_err_cnt = m_err_cnt;
    if (e.e_step || e.e_err || e.e_idx) sb.push_back(e);
  endtask

  task automatic model_reset();
    sb.delete();
    m_pos = 0; m_cnt = 0; m_err_cnt = 0; m_dir = 1'b0; m_ab = 2'b00;
    n_steps = 0; vv_seen = 0;
  endtask

  task automatic applyStimulus(input logic [1:0] ab, input int hold);
    @(negedge clk);
    qa = ab[0];
    qb = ab[1];
    model_apply(ab, 1'b0);
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic go_fwd(input int n, input int hold);
    for (int i = 0; i < n; i++) applyStimulus(gray[(phase_of(m_ab) + 1) % 4], hold);
  endtask

  task automatic go_rev(input int n, input int hold);
    for (int i = 0; i < n; i++) applyStimulus(gray[(phase_of(m_ab) + 3) % 4], hold);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checkOutput(name, sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    qa = 1'b0; qb = 1'b0; qz = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_pos = 0; m_cnt = 0; m_err_cnt = 0;
    checkOutput("clr_pos", pos, 0);
    checkOutput("clr_cnt", cnt, 0);
    checkOutput("clr_err_cnt", err_cnt, 0);
  endtask

  // Cycle count since reset release, used for latency and window timing.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Scoreboard monitor: every step/idx/err pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (vel_valid) begin
        vv_seen++;
        vv_cyc = cyc;
        vv_val = vel;
      end
      if (step) begin
        n_steps++;
        last_step_cyc = cyc;
      end
      if (step || idx || err) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_event", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("ev_step", step, mon_e.e_step);
          checkOutput("ev_idx", idx, mon_e.e_idx);
          checkOutput("ev_err", err, mon_e.e_err);
          checkOutput("ev_pos", pos, mon_e.e_pos);
          checkOutput("ev_cnt", cnt, mon_e.e_cnt);
          checkOutput("ev_dir", dir, mon_e.e_dir);
          checkOutput("ev_err_cnt", err_cnt, mon_e.e_err_cnt);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    int n0;
    int w;
    exp_t e;

    gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
    tbl[0] = '{2'b01, 1'b0,  1,  1, 1'b1, 0};
    tbl[1] = '{2'b11, 1'b0,  2,  2, 1'b1, 0};
    tbl[2] = '{2'b01, 1'b0,  1,  1, 1'b0, 0};
    tbl[3] = '{2'b00, 1'b0,  0,  0, 1'b0, 0};
    tbl[4] = '{2'b10, 1'b0, 15, -1, 1'b0, 0};
    tbl[5] = '{2'b11, 1'b0, 14, -2, 1'b0, 0};
    tbl[6] = '{2'b00, 1'b1, 14, -2, 1'b0, 1};
    tbl[7] = '{2'b10, 1'b0, 13, -3, 1'b0, 1};
    tbl[8] = '{2'b00, 1'b0, 14, -2, 1'b1, 1};

    // Reset state
    #12;
    checkOutput("rst_dir", dir, 0);
    checkOutput("rst_step", step, 0);
    checkOutput("rst_pos", pos, 0);
    checkOutput("rst_cnt", cnt, 0);
    checkOutput("rst_vel", vel, 0);
    checkOutput("rst_vel_valid", vel_valid, 0);
    checkOutput("rst_idx", idx, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // Velocity: 12 forward + 2 reverse inside the first window
    go_fwd(12, 6);
    go_rev(2, 6);
    drain("vel_drain");
    w = 0;
    while (cyc < VEL_WIN + 10 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checkOutput("vel_valid_pulses", vv_seen, 1);
    checkOutput("vel_valid_cycle", vv_cyc, VEL_WIN);
    checkOutput("vel_value", vv_val, 10);

    // Table-driven vectors from a fresh reset
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      qa = tbl[i].ab[0];
      qb = tbl[i].ab[1];
      e.e_step    = ~tbl[i].e_err;
      e.e_idx     = 1'b0;
      e.e_err     = tbl[i].e_err;
      e.e_pos     = tbl[i].e_pos;
      e.e_cnt     = tbl[i].e_cnt;
      e.e_dir     = tbl[i].e_dir;
      e.e_err_cnt = tbl[i].e_err_cnt;
      sb.push_back(e);
      repeat (5) @(negedge clk);
    end
    drain("table_drain");
    m_ab = tbl[8].ab; m_pos = tbl[8].e_pos; m_cnt = tbl[8].e_cnt;
    m_dir = tbl[8].e_dir; m_err_cnt = tbl[8].e_err_cnt;

    // Three-cycle glitch on A must be filtered out
    n0 = n_steps;
    @(negedge clk);
    qa = 1'b1;
    repeat (3) @(negedge clk);
    qa = 1'b0;
    repeat (14) @(negedge clk);
    checkOutput("glitch_no_step", n_steps - n0, 0);

    // Held level change: step registered 2 + FILT_LEN + 1 clocks after the pin edge
    @(negedge clk);
    c0 = cyc;
    qa = 1'b1;
    model_apply(2'b01, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("step_latency", last_step_cyc - c0, 2 + FILT_LEN + 1);
    drain("latency_drain");

    // Position wrap in both directions
    do_reset();
    go_fwd(17, 6);
    drain("fwd17_drain");
    checkOutput("fwd17_pos", pos, 1);
    checkOutput("fwd17_cnt", cnt, 17);
    checkOutput("fwd17_dir", dir, 1);
    go_rev(18, 6);
    drain("rev18_drain");
    checkOutput("rev18_pos", pos, 15);
    checkOutput("rev18_cnt", cnt, -1);
    checkOutput("rev18_dir", dir, 0);

    // Illegal transitions and err_cnt saturation
    do_clr();
    for (int i = 0; i < 300; i++) applyStimulus(~m_ab, 10);
    drain("err_drain");
    checkOutput("err_cnt_sat", err_cnt, ERR_MAX);
    checkOutput("err_pos_kept", pos, 0);
    checkOutput("err_cnt_kept", cnt, 0);

    // Index rising together with a forward step
    do_reset();
    go_fwd(9, 6);
    drain("idx_pre_drain");
    checkOutput("idx_pre_pos", pos, 9);
    @(negedge clk);
    w = (phase_of(m_ab) + 1) % 4;
    qa = gray[w][0];
    qb = gray[w][1];
    qz = 1'b1;
    model_apply(gray[w], 1'b1);
    repeat (10) @(negedge clk);
    drain("idx_drain");
    checkOutput("idx_pos", pos, 0);
    checkOutput("idx_cnt", cnt, 10);
    @(negedge clk);
    qz = 1'b0;
    repeat (10) @(negedge clk);

    // Asynchronous reset mid-stream with pins at 11
    go_fwd(4, 6);
    drain("pre_rst_drain");
    checkOutput("pre_rst_pos", pos, 4);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_pos", pos, 0);
    checkOutput("async_cnt", cnt, 0);
    checkOutput("async_dir", dir, 0);
    checkOutput("async_step", step, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_apply({qb, qa}, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("release_no_step", n_steps, 0);
    drain("release_drain");
    do_clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
